// File: rtl/lfsr_pkg.sv
// Shared types and constants for the parametrised Galois LFSR random-word source.
// Tap masks use the Galois convention: bit i set feeds fb into state bit i.
package lfsr_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_e;

  localparam logic [3:0]  TAPS_4       = 4'h8;
  localparam logic [15:0] TAPS_16      = 16'hD008;
  localparam logic [31:0] TAPS_32      = 32'hD000_0000;
  localparam logic [31:0] SEED_DEFAULT = 32'hD4A5_6AAD;

  // Decimation counter needs at least one bit even when every step delivers a word.
  function automatic int cnt_width(input int decim);
    return (decim > 1) ? $clog2(decim) : 1;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational Galois LFSR next-state: shift left, recirculate the MSB into bit 0,
// and XOR it into every position selected by TAPS.
module lfsr_next #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = 32'hD000_0000
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  logic w_fb;

  assign w_fb   = i_state[WIDTH-1];
  assign o_next = {i_state[WIDTH-2:0], w_fb} ^ (TAPS & {WIDTH{w_fb}});

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random-word source: seed/lockup mux, decimation counter, FILL/HOLD FSM and
// a single-entry output buffer behind a valid/ready handshake.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEFAULT),
  parameter int               OUT_W = 16,
  parameter int               DECIM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int               CNT_W    = cnt_width(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  fsm_e             r_fsm;

  logic w_lockup;
  logic w_step;
  logic w_accept;
  logic w_fill_step;
  logic w_last;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .i_state (r_state),
    .o_next  (w_next)
  );

  assign w_lockup    = (r_state == '0);
  assign w_step      = en && !w_lockup;
  assign w_accept    = (r_fsm == HOLD) && out_ready;
  // A step taken on the accept cycle already belongs to the next word.
  assign w_fill_step = w_step && ((r_fsm == FILL) || w_accept);
  assign w_last      = (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments only; later assignments in
  // the same block deliberately override earlier ones (capture wins over accept).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEED;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_fsm       <= FILL;
    end else if (seed_load) begin
      r_state     <= (seed_in == '0) ? SEED : seed_in;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_fsm       <= FILL;
    end else begin
      if (w_lockup) begin
        r_state <= SEED;
      end else if (en) begin
        r_state <= w_next;
      end

      if (w_accept) begin
        r_out_valid <= 1'b0;
        r_fsm       <= FILL;
      end

      if (w_fill_step) begin
        if (w_last) begin
          r_out_data  <= w_next[OUT_W-1:0];
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_fsm       <= HOLD;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign state     = r_state;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised Galois LFSR random-word source, successor to the fixed 32-bit key-generation LFSR. Width, tap mask, reset seed and output word width are parameters. Adds runtime seed load, all-zero lockup protection, and decimation (DECIM steps between delivered words). Output words are buffered behind a valid/ready handshake toward the key-generation controller. The free-running source of randomness remains the user start-press instant; this block supplies the counter sequence.

Parameters:
WIDTH, 32, LFSR state width (>= 4)
TAPS, 32'hD000_0000, Galois mask: bit i set => state[i] <= state[i-1] ^ fb (bit 0 always <= fb); default = taps 32,31,29,1
SEED, 32'hD4A5_6AAD, reset / lockup-recovery state; must be non-zero
OUT_W, 16, delivered word width (1..WIDTH)
DECIM, 4, LFSR steps per delivered word (>= 1)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous reset, active-low
en  in  1  step enable; one LFSR step per clk while high
seed_load  in  1  load seed_in into state (priority over en)
seed_in  in  WIDTH  runtime seed
state  out  WIDTH  current LFSR state
out_data  out  OUT_W  buffered random word
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts out_data

Behaviour:
- Reset (rst low, async assert, sync-clock release): state=SEED, out_data=0, out_valid=0, decimation counter cnt=0, FSM=FILL.
- Step: fb=state[WIDTH-1]; next = {state[WIDTH-2:0],fb} ^ (TAPS & {WIDTH{fb}}).
- seed_load=1: state <= (seed_in==0 ? SEED : seed_in); cnt<=0; out_valid<=0; FSM<=FILL. Buffered word is discarded; en is ignored that cycle.
- Lockup guard: if state is ever 0 (unreachable except via a fault), the next clock loads SEED regardless of en.
- en=0: state and cnt frozen. The handshake still operates; a word in HOLD can be consumed.
- FSM FILL: each enabled step increments cnt. On the step where cnt==DECIM-1: out_data <= next[OUT_W-1:0]; out_valid<=1; cnt<=0; FSM<=HOLD.
- FSM HOLD: state keeps stepping while en=1; cnt idle at 0; out_data stable. On out_valid & out_ready: out_valid<=0; FSM<=FILL. The same clock's step (if en) counts as the first FILL step (cnt<=1, or capture immediately if DECIM==1).
- Latency: first word valid at the clock edge ending the DECIM-th enabled cycle after reset or seed_load. Sustained throughput is one word per DECIM enabled cycles, with ready held high.
- out_ready is ignored while out_valid=0. No word is ever dropped or overwritten while valid.
- seed_load and out_ready in the same cycle: seed_load wins; the word is not counted as delivered.
- Reset mid-HOLD: out_valid drops asynchronously.

Decomposition:
- Package lfsr_pkg holds: FSM state encoding (FILL, HOLD); default tap masks per width (TAPS_4=4'h8, TAPS_16, TAPS_32=32'hD000_0000); default seed constant.
- One combinational sub-module, lfsr_next (WIDTH, TAPS), computes the next state. The top-level handles the seed/lockup mux, the decimation counter, the FSM and the output buffer.

Test Plan:
- Reset: hold rst low, then release -> state=32'hD4A5_6AAD, out_valid=0, out_data=0.
- Single step (DECIM=1, OUT_W=16): en=1 for one cycle -> state=32'h794A_D55B, out_valid=1, out_data=16'hD55B.
- Period (WIDTH=4, TAPS=4'h8, SEED=4'h1): en held high -> state visits 1,2,4,8,9,B,F,7,E,5,A,D,3,6,C, then returns to 1 after exactly 15 steps.
- Backpressure (DECIM=4): out_ready=0 for 20 cycles -> out_valid stays 1 and out_data stays stable while state keeps stepping. Raise ready for one cycle -> next word valid 4 enabled cycles later and matches the reference model.
- Seed load: seed_load with seed_in=0 -> state=SEED, out_valid=0. seed_load with 32'h1 -> state=1, and the next step gives 32'h2.
- Conflicts: seed_load and out_ready together while HOLD -> FSM=FILL, cnt=0, state=seed_in. en=0 during FILL -> cnt and state frozen, out_valid stays 0.
